// File: rtl/module_lsu_if.sv
// Core-side and memory-side bundles of the load/store unit.
// On the core bundle the core is master; on the memory bundle the LSU is master.
interface lsu_core_if;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        stall_o;
  logic        misaligned_o;
  logic        fault_o;

  modport master (
    output req_i, we_i, funct3_i, addr_i, wdata_i,
    input  rdata_o, done_o, stall_o, misaligned_o, fault_o
  );

  modport slave (
    input  req_i, we_i, funct3_i, addr_i, wdata_i,
    output rdata_o, done_o, stall_o, misaligned_o, fault_o
  );
endinterface

interface lsu_mem_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/module_lsu.sv
// Load/store unit: captures an ALU address/rs2, runs one word-bus access with
// byte-lane steering, load extension, alignment/funct3 checks and a bus timeout.
//
// state  | meaning
// S_IDLE | waiting for req_i; request is checked and captured here
// S_BUS  | bus request active on captured fields; waiting for ack or timeout
// S_DONE | one-cycle completion pulse with latched error flags
module module_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_mis;
  logic        r_flt;
  logic [7:0]  r_tmr;

  state_t      w_state_nxt;
  logic        w_cap;
  logic        w_illegal;
  logic        w_misal;
  logic        w_mis_nxt;
  logic        w_flt_nxt;
  logic [7:0]  w_tmr_nxt;
  logic [31:0] w_rdata_nxt;
  logic [31:0] w_load_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be;
  logic [31:0] w_steer;
  logic        w_bus;
  logic        w_bus_wr;

  // Request checks look at the live inputs because they decide the IDLE exit.
  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    if (core.we_i) begin
      w_illegal = core.funct3_i[2] | (core.funct3_i[1:0] == 2'b11);
    end else begin
      w_illegal = (core.funct3_i == 3'b011) | (core.funct3_i[2:1] == 2'b11);
    end
    case (core.funct3_i[1:0])
      2'b01:   w_misal = core.addr_i[0];
      2'b10:   w_misal = (core.addr_i[1:0] != 2'b00);
      default: w_misal = 1'b0;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0:    w_byte = mem.mem_rdata_i[7:0];
      2'd1:    w_byte = mem.mem_rdata_i[15:8];
      2'd2:    w_byte = mem.mem_rdata_i[23:16];
      default: w_byte = mem.mem_rdata_i[31:24];
    endcase
    w_half = r_addr[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
    case (r_f3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'h000000, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'h0000, w_half};
      default: w_load_data = mem.mem_rdata_i;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_steer = r_wdata;
    case (r_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_steer = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_steer = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_steer = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_mis_nxt   = 1'b0;
    w_flt_nxt   = 1'b0;
    w_tmr_nxt   = r_tmr;
    w_rdata_nxt = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (core.req_i) begin
          w_cap = 1'b1;
          if (w_illegal) begin
            w_state_nxt = S_DONE;
            w_flt_nxt   = 1'b1;
          end else if (w_misal) begin
            w_state_nxt = S_DONE;
            w_mis_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_BUS;
            w_tmr_nxt   = TMR_LOAD;
          end
        end
      end
      S_BUS: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (mem.mem_ack_i) begin
          w_state_nxt = S_DONE;
          if (!r_we) begin
            w_rdata_nxt = w_load_data;
          end
        end else if (r_tmr == 8'd0) begin
          w_state_nxt = S_DONE;
          w_flt_nxt   = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - 8'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_mis   <= 1'b0;
      r_flt   <= 1'b0;
      r_tmr   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_mis   <= w_mis_nxt;
      r_flt   <= w_flt_nxt;
      r_tmr   <= w_tmr_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_cap) begin
        r_we    <= core.we_i;
        r_f3    <= core.funct3_i;
        r_addr  <= core.addr_i;
        r_wdata <= core.wdata_i;
      end
    end
  end

  assign w_bus    = (r_state == S_BUS);
  assign w_bus_wr = w_bus & r_we;

  assign core.stall_o      = ((r_state == S_IDLE) & core.req_i) | w_bus;
  assign core.done_o       = (r_state == S_DONE);
  assign core.misaligned_o = (r_state == S_DONE) & r_mis;
  assign core.fault_o      = (r_state == S_DONE) & r_flt;
  assign core.rdata_o      = r_rdata;

  assign mem.mem_req_o   = w_bus;
  assign mem.mem_we_o    = w_bus_wr;
  assign mem.mem_addr_o  = w_bus ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem.mem_be_o    = w_bus_wr ? w_be : 4'b0000;
  assign mem.mem_wdata_o = w_bus_wr ? w_steer : 32'h0;

endmodule

// File: tb/tb_module_lsu.sv
// Directed vector bench for module_lsu with TIMEOUT_CYCLES=4 and a
// wait-state-programmable memory responder.
module tb_module_lsu;

  logic clk;
  logic rst;

  lsu_core_if core_if ();
  lsu_mem_if  mem_if ();

  module_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .core  (core_if),
    .mem   (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          w;
    bit          ack_en;
    int          exp_done;
    int          exp_req;
    logic        exp_mis;
    logic        exp_flt;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] mrd, input int w,
                              input bit ack_en, input int exp_done, input int exp_req,
                              input logic exp_mis, input logic exp_flt, input logic [31:0] exp_rdata,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_addr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mrd = mrd;
    v.w = w; v.ack_en = ack_en; v.exp_done = exp_done; v.exp_req = exp_req;
    v.exp_mis = exp_mis; v.exp_flt = exp_flt; v.exp_rdata = exp_rdata;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_addr = exp_addr;
    return v;
  endfunction

  // Starts on a negedge in IDLE; returns on the negedge of the IDLE cycle after DONE.
  task automatic run_vec(input int idx, input vec_t v);
    int          done_c;
    int          reqc;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    logic [31:0] ad_s;
    logic        we_s;
    logic        mis_s;
    logic        flt_s;
    logic        stall_done;
    logic [31:0] rd_s;
    done_c = -1; reqc = 0; be_s = 4'h0; wd_s = 32'h0; ad_s = 32'h0; we_s = 1'b0;
    mis_s = 1'b0; flt_s = 1'b0; stall_done = 1'b1; rd_s = 32'h0;
    core_if.req_i      = 1'b1;
    core_if.we_i       = v.we;
    core_if.funct3_i   = v.f3;
    core_if.addr_i     = v.addr;
    core_if.wdata_i    = v.wdata;
    mem_if.mem_rdata_i = v.mrd;
    mem_if.mem_ack_i   = 1'b0;
    #1;
    chk($sformatf("v%0d stall_req", idx), {31'h0, core_if.stall_o}, 32'h1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      // Captured fields must be used, so scramble the live ones.
      core_if.addr_i  = 32'hFFFF_FFFF;
      core_if.wdata_i = 32'h5A5A_5A5A;
      if (mem_if.mem_req_o) begin
        reqc++;
        be_s = mem_if.mem_be_o;
        wd_s = mem_if.mem_wdata_o;
        ad_s = mem_if.mem_addr_o;
        we_s = mem_if.mem_we_o;
        mem_if.mem_ack_i = v.ack_en && (reqc - 1 == v.w);
      end else begin
        mem_if.mem_ack_i = 1'b0;
      end
      if (core_if.done_o) begin
        done_c     = c;
        mis_s      = core_if.misaligned_o;
        flt_s      = core_if.fault_o;
        rd_s       = core_if.rdata_o;
        stall_done = core_if.stall_o;
        break;
      end
    end
    core_if.req_i    = 1'b0;
    mem_if.mem_ack_i = 1'b0;
    chk($sformatf("v%0d done_cycle", idx), 32'(done_c), 32'(v.exp_done));
    chk($sformatf("v%0d req_cycles", idx), 32'(reqc), 32'(v.exp_req));
    chk($sformatf("v%0d misaligned", idx), {31'h0, mis_s}, {31'h0, v.exp_mis});
    chk($sformatf("v%0d fault", idx), {31'h0, flt_s}, {31'h0, v.exp_flt});
    chk($sformatf("v%0d rdata", idx), rd_s, v.exp_rdata);
    chk($sformatf("v%0d stall_done", idx), {31'h0, stall_done}, 32'h0);
    if (v.exp_req > 0) begin
      chk($sformatf("v%0d mem_addr", idx), ad_s, v.exp_addr);
      chk($sformatf("v%0d mem_be", idx), {28'h0, be_s}, {28'h0, v.exp_be});
      chk($sformatf("v%0d mem_wdata", idx), wd_s, v.exp_wdata);
      chk($sformatf("v%0d mem_we", idx), {31'h0, we_s}, {31'h0, v.we});
    end
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", idx), {31'h0, core_if.done_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  dn_mask;
    logic [6:0]  st_mask;
    logic        we_c1;
    logic        we_c4;

    //           we    f3      addr          wdata         mrd           w  ack done req mis  flt  rdata         be       wdata         addr
    vecs[0]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8081_F2F3, 0, 1, 2, 1, 1'b0, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0,        32'h0000_0100);
    vecs[1]  = mk(1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h8081_F2F3, 0, 1, 2, 1, 1'b0, 1'b0, 32'h0000_00F2, 4'b0000, 32'h0,        32'h0000_0100);
    vecs[2]  = mk(1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8081_F2F3, 0, 1, 2, 1, 1'b0, 1'b0, 32'hFFFF_8081, 4'b0000, 32'h0,        32'h0000_0100);
    vecs[3]  = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'h8081_F2F3, 0, 1, 2, 1, 1'b0, 1'b0, 32'h8081_F2F3, 4'b0000, 32'h0,        32'h0000_0100);
    vecs[4]  = mk(1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h8081_F2F3, 0, 1, 2, 1, 1'b0, 1'b0, 32'h0000_F2F3, 4'b0000, 32'h0,        32'h0000_0100);
    vecs[5]  = mk(1'b1, 3'b000, 32'h0000_0202, 32'h1234_56AB, 32'hDEAD_BEEF, 0, 1, 2, 1, 1'b0, 1'b0, 32'h0000_F2F3, 4'b0100, 32'hABAB_ABAB, 32'h0000_0200);
    vecs[6]  = mk(1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'hDEAD_BEEF, 0, 1, 2, 1, 1'b0, 1'b0, 32'h0000_F2F3, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0200);
    vecs[7]  = mk(1'b1, 3'b010, 32'h0000_0200, 32'h1122_3344, 32'hDEAD_BEEF, 0, 1, 2, 1, 1'b0, 1'b0, 32'h0000_F2F3, 4'b1111, 32'h1122_3344, 32'h0000_0200);
    vecs[8]  = mk(1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'hDEAD_BEEF, 0, 1, 1, 0, 1'b1, 1'b0, 32'h0000_F2F3, 4'b0000, 32'h0,        32'h0);
    vecs[9]  = mk(1'b1, 3'b001, 32'h0000_0301, 32'h0000_1111, 32'hDEAD_BEEF, 0, 1, 1, 0, 1'b1, 1'b0, 32'h0000_F2F3, 4'b0000, 32'h0,        32'h0);
    vecs[10] = mk(1'b0, 3'b011, 32'h0000_0300, 32'h0,        32'hDEAD_BEEF, 0, 1, 1, 0, 1'b0, 1'b1, 32'h0000_F2F3, 4'b0000, 32'h0,        32'h0);
    vecs[11] = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h7F00_0000, 2, 1, 4, 3, 1'b0, 1'b0, 32'h0000_007F, 4'b0000, 32'h0,        32'h0000_0100);
    vecs[12] = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'h1111_1111, 0, 0, 5, 4, 1'b0, 1'b1, 32'h0000_007F, 4'b0000, 32'h0,        32'h0000_0100);
    vecs[13] = mk(1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h1234_8001, 3, 1, 5, 4, 1'b0, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0,        32'h0000_0100);
    vecs[14] = mk(1'b1, 3'b011, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 0, 1, 1, 0, 1'b0, 1'b1, 32'hFFFF_8001, 4'b0000, 32'h0,        32'h0);
    vecs[15] = mk(1'b0, 3'b110, 32'h0000_0101, 32'h0,        32'hDEAD_BEEF, 0, 1, 1, 0, 1'b0, 1'b1, 32'hFFFF_8001, 4'b0000, 32'h0,        32'h0);
    vecs[16] = mk(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00AB, 32'hDEAD_BEEF, 1, 1, 3, 2, 1'b0, 1'b0, 32'hFFFF_8001, 4'b1000, 32'hABAB_ABAB, 32'h0000_0200);

    rst = 1'b1;
    core_if.req_i = 1'b0; core_if.we_i = 1'b0; core_if.funct3_i = 3'b000;
    core_if.addr_i = 32'h0; core_if.wdata_i = 32'h0;
    mem_if.mem_ack_i = 1'b0; mem_if.mem_rdata_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset mem_req", {31'h0, mem_if.mem_req_o}, 32'h0);
    chk("reset done", {31'h0, core_if.done_o}, 32'h0);
    chk("reset rdata", core_if.rdata_o, 32'h0);
    chk("reset stall", {31'h0, core_if.stall_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset in the middle of a bus access, followed by a stray ack.
    core_if.req_i = 1'b1; core_if.we_i = 1'b0; core_if.funct3_i = 3'b010;
    core_if.addr_i = 32'h0000_0100; mem_if.mem_ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midbus mem_req", {31'h0, mem_if.mem_req_o}, 32'h1);
    rst = 1'b1;
    core_if.req_i = 1'b0;
    @(negedge clk);
    chk("midbus rst mem_req", {31'h0, mem_if.mem_req_o}, 32'h0);
    chk("midbus rst done", {31'h0, core_if.done_o}, 32'h0);
    chk("midbus rst rdata", core_if.rdata_o, 32'h0);
    chk("midbus rst addr", mem_if.mem_addr_o, 32'h0);
    rst = 1'b0;
    mem_if.mem_ack_i = 1'b1;
    @(negedge clk);
    mem_if.mem_ack_i = 1'b0;
    chk("late ack done a", {31'h0, core_if.done_o}, 32'h0);
    @(negedge clk);
    chk("late ack done b", {31'h0, core_if.done_o}, 32'h0);

    // Back-to-back sw then lw to the same word with req held.
    core_if.req_i = 1'b1; core_if.we_i = 1'b1; core_if.funct3_i = 3'b010;
    core_if.addr_i = 32'h0000_0200; core_if.wdata_i = 32'hCAFE_F00D;
    mem_if.mem_rdata_i = 32'hCAFE_F00D;
    dn_mask = 7'h0; st_mask = 7'h0; we_c1 = 1'b0; we_c4 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      #1;
      st_mask[c] = core_if.stall_o;
      dn_mask[c] = core_if.done_o;
      if (c == 1) we_c1 = mem_if.mem_we_o;
      if (c == 4) we_c4 = mem_if.mem_we_o;
      mem_if.mem_ack_i = mem_if.mem_req_o;
      if (core_if.done_o && c < 3) begin
        core_if.we_i = 1'b0;
        core_if.wdata_i = 32'h0;
      end else if (core_if.done_o) begin
        core_if.req_i = 1'b0;
      end
      @(negedge clk);
    end
    mem_if.mem_ack_i = 1'b0;
    chk("b2b done pattern", {25'h0, dn_mask}, {25'h0, 7'b0100100});
    chk("b2b stall pattern", {25'h0, st_mask}, {25'h0, 7'b0011011});
    chk("b2b store we", {31'h0, we_c1}, 32'h1);
    chk("b2b load we", {31'h0, we_c4}, 32'h0);
    chk("b2b rdata", core_if.rdata_o, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
